memory_writeback_stage: RTL and testbench

MEMORY_WRITEBACK_STAGE -- requirements
Module: memory_writeback_stage

---
 rtl/memory_writeback_stage.sv | 158 +++++++++++++++
 tb/tb_memory_writeback_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback_stage.sv
// Memory/writeback pipeline stage: holds the M instruction, runs the data-memory
// request/response handshake, and loads the register-file write port (W).
module memory_writeback_stage #(
  parameter int DPW = 32,
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           arst_ni,
  input  logic           validE,
  input  logic           regwriteE,
  input  logic           resultsrcE,
  input  logic           memwriteE,
  input  logic [DPW-1:0] alu_resultE,
  input  logic [DPW-1:0] wdataE,
  input  logic [ADW-1:0] RdE,
  output logic           stall_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [DPW-1:0] dmem_addr_o,
  output logic [DPW-1:0] dmem_wdata_o,
  input  logic           dmem_gnt_i,
  input  logic           dmem_rvalid_i,
  input  logic [DPW-1:0] dmem_rdata_i,
  output logic [ADW-1:0] RdM,
  output logic           regwriteM,
  output logic [DPW-1:0] alu_resultM,
  output logic [ADW-1:0] addr_3,
  output logic [DPW-1:0] wd_3,
  output logic           we,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_validM;
  logic           r_regwriteM;
  logic           r_resultsrcM;
  logic           r_memwriteM;
  logic [DPW-1:0] r_alu_resultM;
  logic [DPW-1:0] r_wdataM;
  logic [ADW-1:0] r_RdM;
  logic           r_we;
  logic [ADW-1:0] r_addr_3;
  logic [DPW-1:0] r_wd_3;
  logic           w_mem_op;
  logic           w_is_store;
  logic           w_req;
  logic           w_done;
  logic           w_complete;

  // M register: holds while the memory op in M is still outstanding.
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      r_validM      <= 1'b0;
      r_regwriteM   <= 1'b0;
      r_resultsrcM  <= 1'b0;
      r_memwriteM   <= 1'b0;
      r_alu_resultM <= '0;
      r_wdataM      <= '0;
      r_RdM         <= '0;
    end else if (w_complete) begin
      r_validM      <= validE;
      r_regwriteM   <= regwriteE;
      r_resultsrcM  <= resultsrcE;
      r_memwriteM   <= memwriteE;
      r_alu_resultM <= alu_resultE;
      r_wdataM      <= wdataE;
      r_RdM         <= RdE;
    end
  end

  // A store wins over a load when both control bits are set.
  assign w_mem_op   = r_validM & (r_resultsrcM | r_memwriteM);
  assign w_is_store = r_memwriteM;

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Request phase: dmem_req_o is the valid, dmem_gnt_i the ready; a request
  // transfers on a cycle where both are 1, and the request fields stay stable
  // until then. Response phase: dmem_rvalid_i is a valid with no back-pressure,
  // only honoured in RESP.
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          w_req = 1'b1;
          if (dmem_gnt_i) begin
            if (w_is_store) w_done       = 1'b1;
            else            w_next_state = RESP;
          end else begin
            w_next_state = REQ;
          end
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (dmem_gnt_i) begin
          if (w_is_store) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_complete = ~w_mem_op | w_done;

  // W register: a stalled M cycle inserts a bubble and keeps the last address/data.
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      r_we     <= 1'b0;
      r_addr_3 <= '0;
      r_wd_3   <= '0;
    end else if (w_complete) begin
      r_we     <= r_validM & r_regwriteM & (r_RdM != '0);
      r_addr_3 <= r_RdM;
      r_wd_3   <= r_resultsrcM ? dmem_rdata_i : r_alu_resultM;
    end else begin
      r_we     <= 1'b0;
    end
  end

  assign stall_o      = ~w_complete;
  assign dmem_req_o   = w_req;
  assign dmem_we_o    = w_req & r_memwriteM;
  assign dmem_addr_o  = r_alu_resultM;
  assign dmem_wdata_o = r_wdataM;
  assign RdM          = r_RdM;
  assign regwriteM    = r_regwriteM & r_validM;
  assign alu_resultM  = r_alu_resultM;
  assign addr_3       = r_addr_3;
  assign wd_3         = r_wd_3;
  assign we           = r_we;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed bench for memory_writeback_stage: reset, ALU, load, stores, x0 and
// mid-load reset sequences with hand-computed expectations.
module tb_memory_writeback_stage;

  localparam int DPW = 32;
  localparam int ADW = 5;

  logic           clk = 1'b0;
  logic           arst_ni = 1'b1;
  logic           validE, regwriteE, resultsrcE, memwriteE;
  logic [DPW-1:0] alu_resultE, wdataE;
  logic [ADW-1:0] RdE;
  logic           stall_o, dmem_req_o, dmem_we_o;
  logic [DPW-1:0] dmem_addr_o, dmem_wdata_o;
  logic           dmem_gnt_i, dmem_rvalid_i;
  logic [DPW-1:0] dmem_rdata_i;
  logic [ADW-1:0] RdM;
  logic           regwriteM;
  logic [DPW-1:0] alu_resultM;
  logic [ADW-1:0] addr_3;
  logic [DPW-1:0] wd_3;
  logic           we;
  logic [1:0]     o_dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int stall_cnt;

  memory_writeback_stage #(.DPW(DPW), .ADW(ADW)) dut (
    .clk(clk), .arst_ni(arst_ni), .validE(validE), .regwriteE(regwriteE),
    .resultsrcE(resultsrcE), .memwriteE(memwriteE), .alu_resultE(alu_resultE),
    .wdataE(wdataE), .RdE(RdE), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .RdM(RdM), .regwriteM(regwriteM), .alu_resultM(alu_resultM), .addr_3(addr_3),
    .wd_3(wd_3), .we(we), .o_dbg_state(o_dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input logic rw, input logic rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    validE = v; regwriteE = rw; resultsrcE = rs; memwriteE = mw;
    alu_resultE = alu; wdataE = wd; RdE = rd;
  endtask

  task automatic idle_e();
    set_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    idle_e();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    // reset with no clock edge seen yet
    #1 arst_ni = 1'b0;
    #1;
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
    chk("rst_dwe", {31'b0, dmem_we_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_addr3", {27'b0, addr_3}, 32'd0);
    chk("rst_wd3", wd_3, 32'd0);
    chk("rst_rdm", {27'b0, RdM}, 32'd0);
    chk("rst_alum", alu_resultM, 32'd0);
    chk("rst_daddr", dmem_addr_o, 32'd0);
    chk("rst_dwdata", dmem_wdata_o, 32'd0);
    chk("rst_state", {30'b0, o_dbg_state}, 32'd0);
    tick();
    arst_ni = 1'b1;

    // ALU op: first instruction after reset release
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 32'h0, 5'd5);
    tick(); idle_e(); #1;
    chk("alu_c1_req", {31'b0, dmem_req_o}, 32'd0);
    chk("alu_c1_we", {31'b0, we}, 32'd0);
    chk("alu_c1_rdm", {27'b0, RdM}, 32'd5);
    chk("alu_c1_rwm", {31'b0, regwriteM}, 32'd1);
    chk("alu_c1_alum", alu_resultM, 32'h0000_00A5);
    tick(); #1;
    chk("alu_c2_we", {31'b0, we}, 32'd1);
    chk("alu_c2_addr3", {27'b0, addr_3}, 32'd5);
    chk("alu_c2_wd3", wd_3, 32'h0000_00A5);
    chk("alu_c2_req", {31'b0, dmem_req_o}, 32'd0);
    tick(); #1;
    chk("alu_c3_we", {31'b0, we}, 32'd0);

    // load from 0x100, gnt on the 3rd request cycle, rvalid 3 cycles after gnt
    stall_cnt = 0;
    set_e(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7);
    tick(); idle_e(); #1;
    chk("ld_c1_req", {31'b0, dmem_req_o}, 32'd1);
    chk("ld_c1_dwe", {31'b0, dmem_we_o}, 32'd0);
    chk("ld_c1_addr", dmem_addr_o, 32'h0000_0100);
    stall_cnt += int'(stall_o);
    tick(); #1;
    chk("ld_c2_state", {30'b0, o_dbg_state}, 32'd1);
    chk("ld_c2_addr", dmem_addr_o, 32'h0000_0100);
    stall_cnt += int'(stall_o);
    tick(); dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_0BAD; #1;
    chk("ld_c3_req", {31'b0, dmem_req_o}, 32'd1);
    chk("ld_c3_addr", dmem_addr_o, 32'h0000_0100);
    stall_cnt += int'(stall_o);
    tick(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; #1;
    chk("ld_c4_state", {30'b0, o_dbg_state}, 32'd2);
    chk("ld_c4_req", {31'b0, dmem_req_o}, 32'd0);
    stall_cnt += int'(stall_o);
    tick(); #1;
    chk("ld_c5_rdm", {27'b0, RdM}, 32'd7);
    stall_cnt += int'(stall_o);
    tick(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF; #1;
    chk("ld_c6_stall", {31'b0, stall_o}, 32'd0);
    stall_cnt += int'(stall_o);
    chk("ld_stall_cycles", stall_cnt, 32'd5);
    tick(); dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; #1;
    chk("ld_c7_we", {31'b0, we}, 32'd1);
    chk("ld_c7_addr3", {27'b0, addr_3}, 32'd7);
    chk("ld_c7_wd3", wd_3, 32'hDEAD_BEEF);
    chk("ld_c7_state", {30'b0, o_dbg_state}, 32'd0);
    tick(); #1;
    chk("ld_c8_we", {31'b0, we}, 32'd0);

    // store 0x1234_5678 to 0x200 with immediate gnt
    set_e(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0);
    tick(); idle_e(); dmem_gnt_i = 1'b1; #1;
    chk("st_req", {31'b0, dmem_req_o}, 32'd1);
    chk("st_dwe", {31'b0, dmem_we_o}, 32'd1);
    chk("st_addr", dmem_addr_o, 32'h0000_0200);
    chk("st_wdata", dmem_wdata_o, 32'h1234_5678);
    chk("st_stall", {31'b0, stall_o}, 32'd0);
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("st_c2_req", {31'b0, dmem_req_o}, 32'd0);
    chk("st_c2_we", {31'b0, we}, 32'd0);
    chk("st_c2_state", {30'b0, o_dbg_state}, 32'd0);

    // back-to-back stores, each granted immediately
    set_e(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'hAAAA_0001, 5'd0);
    tick();
    set_e(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 32'hAAAA_0002, 5'd0);
    dmem_gnt_i = 1'b1; #1;
    chk("b2b_a_addr", dmem_addr_o, 32'h0000_0300);
    tick(); idle_e(); #1;
    chk("b2b_b_req", {31'b0, dmem_req_o}, 32'd1);
    chk("b2b_b_addr", dmem_addr_o, 32'h0000_0304);
    chk("b2b_b_wdata", dmem_wdata_o, 32'hAAAA_0002);
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("b2b_done_req", {31'b0, dmem_req_o}, 32'd0);

    // ALU write to x0 with an unsolicited rvalid in IDLE
    set_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    tick(); idle_e(); #1;
    chk("x0_c1_state", {30'b0, o_dbg_state}, 32'd0);
    chk("x0_c1_stall", {31'b0, stall_o}, 32'd0);
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("x0_c2_we", {31'b0, we}, 32'd0);
    chk("x0_c2_state", {30'b0, o_dbg_state}, 32'd0);

    // reset while waiting in RESP, then a late rvalid
    set_e(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd9);
    tick(); idle_e(); dmem_gnt_i = 1'b1; #1;
    chk("mr_c1_req", {31'b0, dmem_req_o}, 32'd1);
    tick(); dmem_gnt_i = 1'b0; #1;
    chk("mr_c2_state", {30'b0, o_dbg_state}, 32'd2);
    chk("mr_c2_stall", {31'b0, stall_o}, 32'd1);
    arst_ni = 1'b0; #1;
    chk("mr_rst_state", {30'b0, o_dbg_state}, 32'd0);
    chk("mr_rst_stall", {31'b0, stall_o}, 32'd0);
    chk("mr_rst_rdm", {27'b0, RdM}, 32'd0);
    chk("mr_rst_req", {31'b0, dmem_req_o}, 32'd0);
    arst_ni = 1'b1;
    tick(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_0BAD; #1;
    chk("mr_late_state", {30'b0, o_dbg_state}, 32'd0);
    tick(); dmem_rvalid_i = 1'b0; #1;
    chk("mr_late_we", {31'b0, we}, 32'd0);
    chk("mr_late_addr3", {27'b0, addr_3}, 32'd0);
    tick(); #1;
    chk("mr_late2_we", {31'b0, we}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
